// File: rtl/eth_gen_pkg.sv
// Shared definitions for the GMII frame generator.
// Holds the per-port FSM state encoding, on-wire framing constants and the
// byte-wide reflected CRC32 update used for FCS generation.
package eth_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_HDR,
    ST_PAY,
    ST_FCS,
    ST_IFG,
    ST_DONE
  } gen_state_e;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [15:0] ETHERTYPE   = 16'h88B5;
  localparam int          MIN_PAYLOAD = 46;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam int PRE_BYTES = 7;
  localparam int HDR_BYTES = 14;
  localparam int FCS_BYTES = 4;

  // One byte of the LSB-first (reflected) CRC32, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_frame_gen_port.sv
// One GMII frame generator channel.
// Ports:
//   clk, arst_n      byte clock, async active-low reset
//   start_i          restart pulse (aborts any frame in flight)
//   en_i             channel enable, only looked at together with start_i
//   len_i, ifg_i     clamped payload length / gap length (held by the top)
//   frames_i         frames to send, 0 = continuous
//   err_i            invert FCS bytes and raise txer during FCS
//   txd_o/txen_o/txer_o  registered GMII outputs
//   done_o           frame budget exhausted
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | not started or disabled, outputs quiet
// PRE     | 7 preamble bytes
// SFD     | start-of-frame delimiter
// HDR     | 14 header bytes (dst, src, ethertype)
// PAY     | len_i payload bytes, value seq+i
// FCS     | 4 CRC bytes, LSB first
// IFG     | ifg_i idle bytes
// DONE    | all frames sent, done_o high
//
// Outputs are a one-cycle registered image of the current state, so the
// wire lags state_q by one edge; start_i forces the image to idle at once.
module gmii_frame_gen_port
  import eth_gen_pkg::*;
#(
  parameter int         LEN_W    = 11,
  parameter int         FRAMES_W = 16,
  parameter logic [7:0] NODE     = 8'h01
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                start_i,
  input  logic                en_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [7:0]          ifg_i,
  input  logic [FRAMES_W-1:0] frames_i,
  input  logic                err_i,
  output logic [7:0]          txd_o,
  output logic                txen_o,
  output logic                txer_o,
  output logic                done_o
);

  localparam logic [LEN_W-1:0]    CNT_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0]    CNT_PRE = LEN_W'(PRE_BYTES - 1);
  localparam logic [LEN_W-1:0]    CNT_HDR = LEN_W'(HDR_BYTES - 1);
  localparam logic [LEN_W-1:0]    CNT_FCS = LEN_W'(FCS_BYTES - 1);
  localparam logic [FRAMES_W-1:0] SEQ_ONE = FRAMES_W'(1);

  gen_state_e          state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [FRAMES_W-1:0] seq_q, seq_d;
  logic [7:0]          pay_q, pay_d;
  logic [31:0]         crc_q, crc_d;
  logic [7:0]          txd_d;
  logic                txen_d, txer_d, done_d;

  logic                tc;
  logic [3:0]          hdr_idx;
  logic [7:0]          hdr_byte;
  logic [31:0]         fcs_word;
  logic [7:0]          fcs_byte;

  assign tc = (cnt_q == '0);

  always_comb begin
    hdr_idx  = 4'd13 - cnt_q[3:0];
    hdr_byte = 8'h00;
    case (hdr_idx)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: hdr_byte = 8'hFF;
      4'd6:    hdr_byte = 8'h02;
      4'd11:   hdr_byte = NODE;
      4'd12:   hdr_byte = ETHERTYPE[15:8];
      4'd13:   hdr_byte = ETHERTYPE[7:0];
      default: hdr_byte = 8'h00;
    endcase

    fcs_word = ~crc_q;
    case (cnt_q[1:0])
      2'd3:    fcs_byte = fcs_word[7:0];
      2'd2:    fcs_byte = fcs_word[15:8];
      2'd1:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
    if (err_i) fcs_byte = ~fcs_byte;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tc ? cnt_q : cnt_q - CNT_ONE;
    seq_d   = seq_q;
    pay_d   = pay_q;
    crc_d   = crc_q;
    txd_d   = 8'h00;
    txen_d  = 1'b0;
    txer_d  = 1'b0;
    done_d  = (state_q == ST_DONE);

    case (state_q)
      ST_PRE: begin
        txd_d  = PREAMBLE;
        txen_d = 1'b1;
        crc_d  = CRC_INIT;
        if (tc) state_d = ST_SFD;
      end
      ST_SFD: begin
        txd_d   = SFD;
        txen_d  = 1'b1;
        state_d = ST_HDR;
        cnt_d   = CNT_HDR;
      end
      ST_HDR: begin
        txd_d  = hdr_byte;
        txen_d = 1'b1;
        crc_d  = crc32_byte(crc_q, hdr_byte);
        if (tc) begin
          state_d = ST_PAY;
          cnt_d   = len_i - CNT_ONE;
          pay_d   = seq_q[7:0];
        end
      end
      ST_PAY: begin
        txd_d  = pay_q;
        txen_d = 1'b1;
        crc_d  = crc32_byte(crc_q, pay_q);
        pay_d  = pay_q + 8'd1;
        if (tc) begin
          state_d = ST_FCS;
          cnt_d   = CNT_FCS;
        end
      end
      ST_FCS: begin
        txd_d  = fcs_byte;
        txen_d = 1'b1;
        txer_d = err_i;
        if (tc) begin
          state_d = ST_IFG;
          cnt_d   = LEN_W'(ifg_i) - CNT_ONE;
        end
      end
      ST_IFG: begin
        if (tc) begin
          seq_d = seq_q + SEQ_ONE;
          if ((frames_i != '0) && (seq_d == frames_i)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PRE;
            cnt_d   = CNT_PRE;
          end
        end
      end
      default: ;
    endcase

    if (start_i) begin
      state_d = en_i ? ST_PRE : ST_IDLE;
      cnt_d   = CNT_PRE;
      seq_d   = '0;
      crc_d   = CRC_INIT;
      txd_d   = 8'h00;
      txen_d  = 1'b0;
      txer_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seq_q   <= '0;
      pay_q   <= 8'h00;
      crc_q   <= CRC_INIT;
      txd_o   <= 8'h00;
      txen_o  <= 1'b0;
      txer_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      pay_q   <= pay_d;
      crc_q   <= crc_d;
      txd_o   <= txd_d;
      txen_o  <= txen_d;
      txer_o  <= txer_d;
      done_o  <= done_d;
    end
  end

endmodule

// File: rtl/gmii_frame_gen.sv
// Multi-port GMII frame generator.
// Ports:
//   clk, arst_n        byte clock, async active-low reset
//   start              latches cfg_* and restarts every port
//   cfg_en, cfg_len, cfg_ifg, cfg_frames, cfg_err_inj   run configuration
//   txd, txen, txer    per-port GMII outputs
//   done               per-port completion
//   halt_req           every enabled port has completed
// Configuration is clamped and held here so that live cfg_* changes between
// start pulses have no effect on running ports.
module gmii_frame_gen
  import eth_gen_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int START_NODE = 1,
  parameter int LEN_W      = 11,
  parameter int MAX_LEN    = 1500,
  parameter int MIN_IFG    = 12,
  parameter int FRAMES_W   = 16
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      start,
  input  logic [NUM_PORTS-1:0]      cfg_en,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic [7:0]                cfg_ifg,
  input  logic [FRAMES_W-1:0]       cfg_frames,
  input  logic [NUM_PORTS-1:0]      cfg_err_inj,
  output logic [NUM_PORTS-1:0][7:0] txd,
  output logic [NUM_PORTS-1:0]      txen,
  output logic [NUM_PORTS-1:0]      txer,
  output logic [NUM_PORTS-1:0]      done,
  output logic                      halt_req
);

  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_PAYLOAD);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [7:0]       IFG_MIN = 8'(MIN_IFG);

  logic [NUM_PORTS-1:0] en_q, en_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [7:0]           ifg_q, ifg_d;
  logic [FRAMES_W-1:0]  frames_q, frames_d;
  logic                 halt_d;

  always_comb begin
    en_d     = en_q;
    err_d    = err_q;
    len_d    = len_q;
    ifg_d    = ifg_q;
    frames_d = frames_q;
    if (start) begin
      en_d     = cfg_en;
      err_d    = cfg_err_inj;
      frames_d = cfg_frames;
      if (cfg_len < LEN_MIN)      len_d = LEN_MIN;
      else if (cfg_len > LEN_MAX) len_d = LEN_MAX;
      else                        len_d = cfg_len;
      ifg_d = (cfg_ifg < IFG_MIN) ? IFG_MIN : cfg_ifg;
    end
    halt_d = start ? 1'b0 : ((|en_q) && ((done & en_q) == en_q));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      en_q     <= '0;
      err_q    <= '0;
      len_q    <= LEN_MIN;
      ifg_q    <= IFG_MIN;
      frames_q <= '0;
      halt_req <= 1'b0;
    end else begin
      en_q     <= en_d;
      err_q    <= err_d;
      len_q    <= len_d;
      ifg_q    <= ifg_d;
      frames_q <= frames_d;
      halt_req <= halt_d;
    end
  end

  // The port sees the raw enable alongside start so it can leave IDLE on the
  // same edge the configuration is latched.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    gmii_frame_gen_port #(
      .LEN_W    (LEN_W),
      .FRAMES_W (FRAMES_W),
      .NODE     (8'((START_NODE + p) % 256))
    ) u_port (
      .clk      (clk),
      .arst_n   (arst_n),
      .start_i  (start),
      .en_i     (cfg_en[p]),
      .len_i    (len_q),
      .ifg_i    (ifg_q),
      .frames_i (frames_q),
      .err_i    (err_q[p]),
      .txd_o    (txd[p]),
      .txen_o   (txen[p]),
      .txer_o   (txer[p]),
      .done_o   (done[p])
    );
  end

endmodule

// File: tb/tb_gmii_frame_gen.sv
`timescale 1ns/1ps
module tb_gmii_frame_gen;
  localparam int NP = 4;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] cfg_en = '0;
  logic [10:0] cfg_len = '0;
  logic [7:0] cfg_ifg = '0;
  logic [15:0] cfg_frames = '0;
  logic [3:0] cfg_err_inj = '0;
  logic [3:0][7:0] txd;
  logic [3:0] txen, txer, done;
  logic halt_req;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int len;
    int seq;
    bit err;
    int ifg;
    bit last;
    bit trunc;
  } exp_t;

  exp_t exp_q[NP][$];
  int frames_seen[NP];
  int start_cyc[NP];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gmii_frame_gen dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .cfg_en(cfg_en), .cfg_len(cfg_len), .cfg_ifg(cfg_ifg),
    .cfg_frames(cfg_frames), .cfg_err_inj(cfg_err_inj),
    .txd(txd), .txen(txen), .txer(txer), .done(done), .halt_req(halt_req)
  );

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Bit-serial reflected CRC32 step: feedback = lsb of register xor data bit.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] hdr_byte(input int p, input int i);
    logic [31:0] node;
    node = 32'(1 + p);
    if (i < 6)   return 8'hFF;
    if (i == 6)  return 8'h02;
    if (i == 11) return node[7:0];
    if (i == 12) return 8'h88;
    if (i == 13) return 8'hB5;
    return 8'h00;
  endfunction

  task automatic push_one(input int p, input int len, input int seq, input bit err,
                          input int ifg, input bit last, input bit trunc);
    exp_t e;
    e.len = len; e.seq = seq; e.err = err; e.ifg = ifg; e.last = last; e.trunc = trunc;
    exp_q[p].push_back(e);
  endtask

  task automatic push_frames(input logic [3:0] en, input int len, input int ifg,
                             input int n, input logic [3:0] err);
    for (int p = 0; p < NP; p++)
      if (en[p])
        for (int k = 0; k < n; k++) push_one(p, len, k, err[p], ifg, k == n - 1, 1'b0);
  endtask

  task automatic pulse(input logic [3:0] en, input int len, input int ifg,
                       input int frames, input logic [3:0] err);
    @(posedge clk); #1;
    cfg_en = en; cfg_len = 11'(len); cfg_ifg = 8'(ifg);
    cfg_frames = 16'(frames); cfg_err_inj = err;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_halt(input int maxc, input string nm);
    int c;
    c = 0;
    while (!halt_req && c < maxc) begin
      @(posedge clk); #1;
      c++;
    end
    chk(halt_req == 1'b1, nm, c, maxc);
  endtask

  task automatic check_align(input logic [3:0] en, input string nm);
    for (int p = 1; p < NP; p++)
      if (en[p]) chk(start_cyc[p] == start_cyc[0], $sformatf("%s align p%0d", nm, p),
                     start_cyc[p], start_cyc[0]);
  endtask

  // Per-port monitor: captures each txen burst and compares it with the
  // next queued expectation; also checks the idle gap between frames.
  for (genvar gp = 0; gp < NP; gp++) begin : g_mon
    initial begin : mon
      logic [7:0] cap[$];
      bit cer[$];
      logic [7:0] ef[0:1599];
      int elen, gap, prev_gap, nmis, first, nerr, nhi;
      bit in_fr, have_prev, prev_last, exp_er;
      exp_t e;
      logic [31:0] crc;
      logic [7:0] b;
      in_fr = 0; have_prev = 0; prev_last = 1; gap = 0; prev_gap = 0;
      forever begin
        @(negedge clk);
        if (txen[gp]) begin
          if (!in_fr) begin
            if (have_prev && !prev_last)
              chk(gap == prev_gap, $sformatf("gap p%0d", gp), gap, prev_gap);
            in_fr = 1; cap.delete(); cer.delete(); start_cyc[gp] = cyc;
          end
          cap.push_back(txd[gp]);
          cer.push_back(txer[gp]);
        end else begin
          chk(txd[gp] == 8'h00 && txer[gp] == 1'b0, $sformatf("idle p%0d txd/txer", gp),
              {txd[gp], txer[gp]}, 0);
          if (!in_fr) gap++;
          else begin
            in_fr = 0; gap = 1;
            if (exp_q[gp].size() == 0) begin
              chk(1'b0, $sformatf("unexpected frame p%0d len", gp), cap.size(), 0);
            end else begin
              e = exp_q[gp].pop_front();
              frames_seen[gp]++;
              elen = 26 + e.len;
              for (int i = 0; i < 7; i++) ef[i] = 8'h55;
              ef[7] = 8'hD5;
              for (int i = 0; i < 14; i++) ef[8 + i] = hdr_byte(gp, i);
              for (int i = 0; i < e.len; i++) ef[22 + i] = 8'(e.seq + i);
              crc = 32'hFFFFFFFF;
              for (int i = 8; i < 22 + e.len; i++) crc = crc_upd(crc, ef[i]);
              crc = ~crc;
              for (int k = 0; k < 4; k++) begin
                b = crc[8*k +: 8];
                ef[22 + e.len + k] = e.err ? ~b : b;
              end
              if (e.trunc)
                chk(cap.size() > 0 && cap.size() < elen, $sformatf("trunc len p%0d", gp), cap.size(), elen);
              else
                chk(cap.size() == elen, $sformatf("frame len p%0d seq%0d", gp, e.seq), cap.size(), elen);
              nmis = 0; first = -1; nerr = 0; nhi = 0;
              for (int i = 0; i < cap.size() && i < elen; i++) begin
                if (cap[i] !== ef[i]) begin
                  if (first < 0) first = i;
                  nmis++;
                end
                exp_er = e.err && (i >= elen - 4);
                if (cer[i] != exp_er) nerr++;
                if (cer[i]) nhi++;
              end
              chk(nmis == 0, $sformatf("frame bytes p%0d seq%0d idx%0d", gp, e.seq, first),
                  (first >= 0) ? cap[first] : 0, (first >= 0) ? ef[first] : 0);
              chk(nerr == 0, $sformatf("txer placement p%0d seq%0d", gp, e.seq), nerr, 0);
              if (!e.trunc) begin
                chk(nhi == (e.err ? 4 : 0), $sformatf("txer cycles p%0d", gp), nhi, e.err ? 4 : 0);
                crc = 32'hFFFFFFFF;
                for (int i = 8; i < cap.size(); i++) crc = crc_upd(crc, cap[i]);
                chk((crc == RESIDUE) == !e.err, $sformatf("residue p%0d err%0d", gp, e.err),
                    crc, RESIDUE);
              end
              prev_gap = e.ifg; prev_last = e.last; have_prev = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c, seen;
    int base[NP];
    repeat (3) @(posedge clk);
    #1;
    chk(txen == 4'h0, "reset txen", txen, 0);
    chk(txd == 32'h0, "reset txd", txd, 0);
    chk(txer == 4'h0, "reset txer", txer, 0);
    chk(done == 4'h0, "reset done", done, 0);
    chk(halt_req == 1'b0, "reset halt_req", halt_req, 0);
    arst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single minimal frame on port 0
    push_frames(4'b0001, 46, 12, 1, 4'b0000);
    pulse(4'b0001, 46, 12, 1, 4'b0000);
    c = 0;
    while (!done[0] && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk(c == 85, "t1 done latency", c, 85);
    chk(halt_req == 1'b0, "t1 halt with done", halt_req, 0);
    @(posedge clk); #1;
    chk(halt_req == 1'b1, "t1 halt next cycle", halt_req, 1);
    chk(done[3:1] == 3'b000, "t1 other done", done[3:1], 0);
    chk(frames_seen[0] == 1, "t1 frames", frames_seen[0], 1);

    // All ports, max length, 3 frames; live cfg changes must be ignored
    for (int p = 0; p < NP; p++) base[p] = frames_seen[p];
    push_frames(4'b1111, 1500, 12, 3, 4'b0000);
    pulse(4'b1111, 1500, 12, 3, 4'b0000);
    cfg_len = 11'd100; cfg_frames = 16'd1; cfg_err_inj = 4'hF; cfg_ifg = 8'd50;
    wait_halt(6000, "t2 halt timeout");
    repeat (2) @(posedge clk);
    for (int p = 0; p < NP; p++)
      chk(frames_seen[p] - base[p] == 3, $sformatf("t2 frames p%0d", p), frames_seen[p] - base[p], 3);
    check_align(4'b1111, "t2");

    // Clamping: len 10 -> 46, ifg 3 -> 12
    push_frames(4'b0001, 46, 12, 2, 4'b0000);
    pulse(4'b0001, 10, 3, 2, 4'b0000);
    wait_halt(400, "t3 halt timeout");

    // Error injection on port 1
    push_frames(4'b1111, 46, 12, 2, 4'b0010);
    pulse(4'b1111, 46, 12, 2, 4'b0010);
    wait_halt(400, "t4 halt timeout");
    check_align(4'b1111, "t4");

    // Continuous run, restart mid-payload of the tenth frame
    for (int k = 0; k < 9; k++) push_one(0, 46, k, 1'b0, 12, 1'b0, 1'b0);
    push_one(0, 46, 9, 1'b0, 1, 1'b0, 1'b1);
    push_one(0, 46, 0, 1'b0, 12, 1'b1, 1'b0);
    pulse(4'b0001, 46, 12, 0, 4'b0000);
    repeat (788) @(posedge clk);
    #1;
    chk(txen[0] == 1'b1, "t5 mid-payload before restart", txen[0], 1);
    cfg_frames = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk(txen[0] == 1'b0, "t5 txen drop", txen[0], 0);
    @(posedge clk); #1;
    chk(txen[0] == 1'b1 && txd[0] == 8'h55, "t5 restart preamble", {txen[0], txd[0]}, 9'h155);
    wait_halt(200, "t5 halt timeout");

    // Async reset in the middle of FCS
    for (int p = 0; p < NP; p++) push_one(p, 46, 0, 1'b0, 12, 1'b1, 1'b1);
    pulse(4'b1111, 46, 12, 0, 4'b0000);
    repeat (70) @(posedge clk);
    #3;
    chk(txen == 4'hF, "t6 txen before reset", txen, 4'hF);
    arst_n = 1'b0;
    #1;
    chk(txen == 4'h0, "t6 reset txen", txen, 0);
    chk(txd == 32'h0, "t6 reset txd", txd, 0);
    chk(txer == 4'h0, "t6 reset txer", txer, 0);
    chk(done == 4'h0 && halt_req == 1'b0, "t6 reset done/halt", {done, halt_req}, 0);
    #20;
    arst_n = 1'b1;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (txen != 4'h0) seen++;
    end
    chk(seen == 0, "t6 quiet after reset", seen, 0);

    for (int p = 0; p < NP; p++)
      chk(exp_q[p].size() == 0, $sformatf("leftover expectations p%0d", p), exp_q[p].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
